// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: tracks slot position from frame_sync and routes samples to per-channel registers.
// Optional TDM_DEMUX_FRAME_BUFFER_EN: capture into a shadow bank and publish whole frames atomically.
module tdm_demux #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        din,
   input  logic                    din_valid,
   input  logic                    frame_sync,
   output logic [NUM_CH*WIDTH-1:0] ch_out,
   output logic [NUM_CH-1:0]       ch_valid,
   output logic                    frame_done,
   output logic                    locked,
   output logic                    sync_err
);

   // state | meaning
   // HUNT  | waiting for a valid sample flagged with frame_sync
   // LOCK  | slot counter aligned to the frame, samples routed by slot
   typedef enum logic {HUNT, LOCK} state_t;

   localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

   state_t                  state, state_nxt;
   logic [SW-1:0]           slot, slot_nxt;
   logic                    cap_en;
   logic [SW-1:0]           cap_ch;
   logic                    err_nxt;
   logic                    done_nxt;
   logic [NUM_CH*WIDTH-1:0] base, merged;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HUNT;
         slot  <= '0;
      end else begin
         state <= state_nxt;
         slot  <= slot_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      cap_en    = 1'b0;
      cap_ch    = '0;
      err_nxt   = 1'b0;
      if (din_valid) begin
         case (state)
            HUNT: begin
               if (frame_sync) begin
                  cap_en    = 1'b1;
                  slot_nxt  = SW'(1);
                  state_nxt = LOCK;
               end
            end
            LOCK: begin
               if (frame_sync) begin
                  // a sync on slot 0 is the normal case; elsewhere it forces a resync
                  cap_en   = 1'b1;
                  slot_nxt = SW'(1);
                  err_nxt  = (slot != '0);
               end else if (slot == '0) begin
                  err_nxt   = 1'b1;
                  state_nxt = HUNT;
               end else begin
                  cap_en   = 1'b1;
                  cap_ch   = slot;
                  slot_nxt = (slot == LAST) ? '0 : slot + SW'(1);
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   assign done_nxt = cap_en && (cap_ch == LAST);
   assign locked   = (state == LOCK);

`ifdef TDM_DEMUX_FRAME_BUFFER_EN
   logic [NUM_CH*WIDTH-1:0] bank;
   assign base = bank;
`else
   assign base = ch_out;
`endif

   always_comb begin
      merged = base;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cap_en && cap_ch == SW'(k)) merged[k*WIDTH +: WIDTH] = din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_out     <= '0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
`ifdef TDM_DEMUX_FRAME_BUFFER_EN
         bank       <= '0;
`endif
      end else begin
         frame_done <= done_nxt;
         sync_err   <= err_nxt;
`ifdef TDM_DEMUX_FRAME_BUFFER_EN
         bank     <= merged;
         ch_valid <= done_nxt ? '1 : '0;
         if (done_nxt) ch_out <= merged;
`else
         ch_out <= merged;
         for (int k = 0; k < NUM_CH; k++) begin
            ch_valid[k] <= cap_en && (cap_ch == SW'(k));
         end
`endif
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: table-driven 2-channel vectors plus hand sequences for 4-channel resync and async reset.
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic        din_valid;
   logic        frame_sync;
   logic [7:0]  din;

   logic [15:0] ch2;
   logic [1:0]  cv2;
   logic        fd2, lk2, er2;
   logic [31:0] ch4;
   logic [3:0]  cv4;
   logic        fd4, lk4, er4;

   always #5 clk = ~clk;

   tdm_demux #(.WIDTH(8), .NUM_CH(2)) dut2 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
      .ch_out(ch2), .ch_valid(cv2), .frame_done(fd2), .locked(lk2), .sync_err(er2)
   );

   tdm_demux #(.WIDTH(8), .NUM_CH(4)) dut4 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
      .ch_out(ch4), .ch_valid(cv4), .frame_done(fd4), .locked(lk4), .sync_err(er4)
   );

   typedef struct {
      logic        r, v, s;
      logic [7:0]  d;
      logic [15:0] ch;    // per-slot build
      logic [1:0]  cv;
      logic        fd, lk, er;
      logic [15:0] chb;   // frame-buffer build
      logic [1:0]  cvb;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic r, v, s, input logic [7:0] d,
                               input logic [15:0] ch, input logic [1:0] cv,
                               input logic fd, lk, er,
                               input logic [15:0] chb, input logic [1:0] cvb);
      vec_t t;
      t.r = r; t.v = v; t.s = s; t.d = d; t.ch = ch; t.cv = cv;
      t.fd = fd; t.lk = lk; t.er = er; t.chb = chb; t.cvb = cvb;
      tbl.push_back(t);
   endfunction

   task automatic drive(input logic r, v, s, input logic [7:0] d);
      rst = r; din_valid = v; frame_sync = s; din = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_ch2(input logic [15:0] a, input logic [15:0] b);
`ifdef TDM_DEMUX_FRAME_BUFFER_EN
      return b;
`else
      return a;
`endif
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   int fd_cnt, er_cnt;
   logic lk_all;

   initial begin
      rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = '0;

      //   r  v  s  din    ch       cv     fd lk er   chb      cvb
      add(1, 0, 0, 8'h00, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 2'b00);
      add(0, 1, 0, 8'h11, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 2'b00);
      add(0, 1, 0, 8'h22, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 2'b00);
      add(0, 1, 1, 8'hA5, 16'h00A5, 2'b01, 0, 1, 0, 16'h0000, 2'b00);
      add(0, 1, 0, 8'h3C, 16'h3CA5, 2'b10, 1, 1, 0, 16'h3CA5, 2'b11);
      add(0, 1, 1, 8'h7E, 16'h3C7E, 2'b01, 0, 1, 0, 16'h3CA5, 2'b00);
      add(0, 1, 0, 8'h81, 16'h817E, 2'b10, 1, 1, 0, 16'h817E, 2'b11);
      // gapped stream; frame_sync held high in gaps must be ignored
      add(0, 0, 1, 8'hFF, 16'h817E, 2'b00, 0, 1, 0, 16'h817E, 2'b00);
      add(0, 1, 1, 8'hA5, 16'h81A5, 2'b01, 0, 1, 0, 16'h817E, 2'b00);
      for (int g = 0; g < 3; g++)
         add(0, 0, 1, 8'hFF, 16'h81A5, 2'b00, 0, 1, 0, 16'h817E, 2'b00);
      add(0, 1, 0, 8'h3C, 16'h3CA5, 2'b10, 1, 1, 0, 16'h3CA5, 2'b11);
      for (int g = 0; g < 3; g++)
         add(0, 0, 0, 8'hFF, 16'h3CA5, 2'b00, 0, 1, 0, 16'h3CA5, 2'b00);
      add(0, 1, 1, 8'h7E, 16'h3C7E, 2'b01, 0, 1, 0, 16'h3CA5, 2'b00);
      for (int g = 0; g < 3; g++)
         add(0, 0, 1, 8'hFF, 16'h3C7E, 2'b00, 0, 1, 0, 16'h3CA5, 2'b00);
      add(0, 1, 0, 8'h81, 16'h817E, 2'b10, 1, 1, 0, 16'h817E, 2'b11);
      // missing sync on slot 0, then hunt discard and relock
      add(0, 1, 0, 8'h55, 16'h817E, 2'b00, 0, 0, 1, 16'h817E, 2'b00);
      add(0, 1, 0, 8'h66, 16'h817E, 2'b00, 0, 0, 0, 16'h817E, 2'b00);
      add(0, 1, 1, 8'h99, 16'h8199, 2'b01, 0, 1, 0, 16'h817E, 2'b00);
      add(0, 1, 0, 8'h44, 16'h4499, 2'b10, 1, 1, 0, 16'h4499, 2'b11);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
         chk($sformatf("v%0d ch_out", i),     {16'h0, ch2}, {16'h0, exp_ch2(tbl[i].ch, tbl[i].chb)});
         chk($sformatf("v%0d ch_valid", i),   {30'h0, cv2}, {30'h0, exp_ch2({14'h0, tbl[i].cv}, {14'h0, tbl[i].cvb})});
         chk($sformatf("v%0d frame_done", i), {31'h0, fd2}, {31'h0, tbl[i].fd});
         chk($sformatf("v%0d locked", i),     {31'h0, lk2}, {31'h0, tbl[i].lk});
         chk($sformatf("v%0d sync_err", i),   {31'h0, er2}, {31'h0, tbl[i].er});
      end

      // reset mid-frame: slot 0 captured, then async reset with no clock edge
      drive(0, 1, 1, 8'h77);
      chk("midrst pre ch_out", {16'h0, ch2}, {16'h0, exp_ch2(16'h4477, 16'h4499)});
      rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0;
      #2;
      chk("midrst async ch_out",   {16'h0, ch2}, 32'h0);
      chk("midrst async locked",   {31'h0, lk2}, 32'h0);
      chk("midrst async ch_valid", {30'h0, cv2}, 32'h0);
      @(posedge clk); #1;
      drive(0, 1, 0, 8'h88);
      chk("postrst hunt ch_out", {16'h0, ch2}, 32'h0);
      chk("postrst hunt locked", {31'h0, lk2}, 32'h0);
      drive(0, 1, 1, 8'h12);
      chk("postrst sync ch_out",   {16'h0, ch2}, {16'h0, exp_ch2(16'h0012, 16'h0000)});
      chk("postrst sync ch_valid", {30'h0, cv2}, {30'h0, exp_ch2(16'h0001, 16'h0000)});
      drive(0, 1, 0, 8'h34);
      chk("postrst frame ch_out",   {16'h0, ch2}, 32'h3412);
      chk("postrst frame ch_valid", {30'h0, cv2}, {30'h0, exp_ch2(16'h0002, 16'h0003)});
      chk("postrst frame_done",     {31'h0, fd2}, 32'h1);

      // 4-channel early sync
      drive(1, 0, 0, 8'h00);
      chk("ch4 reset ch_out", ch4, 32'h0);
      fd_cnt = 0; er_cnt = 0; lk_all = 1'b1;
      drive(0, 1, 1, 8'h10); fd_cnt += fd4; er_cnt += er4; lk_all &= lk4;
      drive(0, 1, 0, 8'h11); fd_cnt += fd4; er_cnt += er4; lk_all &= lk4;
      drive(0, 1, 1, 8'h20); fd_cnt += fd4; er_cnt += er4; lk_all &= lk4;
      chk("ch4 early sync_err", {31'h0, er4}, 32'h1);
`ifndef TDM_DEMUX_FRAME_BUFFER_EN
      chk("ch4 resync ch_out", ch4, 32'h0000_1120);
`endif
      drive(0, 1, 0, 8'h21); fd_cnt += fd4; er_cnt += er4; lk_all &= lk4;
      drive(0, 1, 0, 8'h22); fd_cnt += fd4; er_cnt += er4; lk_all &= lk4;
      chk("ch4 pre-done frame_done", {31'h0, fd4}, 32'h0);
      drive(0, 1, 0, 8'h23); fd_cnt += fd4; er_cnt += er4; lk_all &= lk4;
      chk("ch4 final ch_out",    ch4, 32'h2322_2120);
      chk("ch4 final frame_done", {31'h0, fd4}, 32'h1);
`ifdef TDM_DEMUX_FRAME_BUFFER_EN
      chk("ch4 final ch_valid", {28'h0, cv4}, 32'hF);
`else
      chk("ch4 final ch_valid", {28'h0, cv4}, 32'h8);
`endif
      chk("ch4 frame_done count", fd_cnt, 32'd1);
      chk("ch4 sync_err count",   er_cnt, 32'd1);
      chk("ch4 locked throughout", {31'h0, lk_all}, 32'h1);
      drive(0, 0, 0, 8'h00);
      chk("ch4 idle ch_valid", {28'h0, cv4}, 32'h0);
      chk("ch4 idle ch_out",   ch4, 32'h2322_2120);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
